// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises PLL lock and button request, then releases
// CHANNELS reset domains in order after a hold time with a fixed stagger.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                locked_async,
  input  logic                btn_req_async,
  input  logic                soft_req,
  output logic [CHANNELS-1:0] resets_out,
  output logic                ready,
  output logic [7:0]          lock_lost_count
);
  localparam int MAXC = HOLD_CYCLES > STAGGER_CYCLES ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d, btn_sync_q, btn_sync_d;
  logic [DW-1:0]          db_q, db_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]    rst_q, rst_d, shifted;
  logic                   ready_q, ready_d;
  logic [7:0]             lost_q, lost_d;
  logic                   locked, btn_sync, btn_req, req;
  assign locked          = lock_sync_q[SYNC_STAGES-1];
  assign btn_sync        = btn_sync_q[SYNC_STAGES-1];
  assign btn_req         = db_q >= DW'(DEBOUNCE_CYCLES);
  assign req             = btn_req | soft_req;
  assign resets_out      = rst_q;
  assign ready           = ready_q;
  assign lock_lost_count = lost_q;
  // The counter reads 1 on the edge that defines T0, both on entry from
  // WAIT_LOCK and on the first req-free edge after a restart.
  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked_async};
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn_req_async};
    db_d        = !btn_sync ? '0 : btn_req ? db_q : db_q + 1'b1;
    shifted     = rst_q << 1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_d       = rst_q;
    ready_d     = ready_q;
    lost_d      = lost_q;
    if (state_q != WAIT_LOCK && !locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      lost_d  = (state_q == RUN && lost_q != 8'hff) ? lost_q + 8'd1 : lost_q;
    end else if (state_q != WAIT_LOCK && req) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else if (state_q == WAIT_LOCK) begin
      state_d = (locked && !req) ? HOLD : WAIT_LOCK;
      cnt_d   = (locked && !req) ? CW'(1) : '0;
    end else if (state_q != RUN) begin
      if (cnt_q == (state_q == HOLD ? CW'(HOLD_CYCLES) : CW'(STAGGER_CYCLES))) begin
        rst_d   = shifted;
        cnt_d   = CW'(1);
        ready_d = shifted == '0;
        state_d = shifted == '0 ? RUN : RELEASE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      db_q        <= '0;
      cnt_q       <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
    end
  end
endmodule
